// File: rtl/cal_pkg.sv
// Shared types and constants for the calibration list loader.
package cal_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 20;
  localparam int unsigned ADDR_WIDTH_DEF = 10;

  localparam logic [7:0] PLUS    = 8'h2B;
  localparam logic [7:0] MINUS   = 8'h2D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] DIGIT_0 = 8'h30;

  typedef enum logic [1:0] {IDLE, LINE, WRITE, DONE} state_e;

endpackage

// File: rtl/ascii_char_classify.sv
// Decodes one ASCII byte into the character classes the line parser cares about.
module ascii_char_classify
  import cal_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_sign_o,
  output logic       is_neg_o,
  output logic       is_lf_o,
  output logic       is_cr_o,
  output logic [3:0] digit_o
);

  logic [7:0] offset;

  // Pure decode; digit_o is only meaningful when is_digit_o is set.
  always_comb begin
    offset     = char_i - DIGIT_0;
    is_digit_o = (char_i >= DIGIT_0) && (char_i <= DIGIT_0 + 8'd9);
    is_sign_o  = (char_i == PLUS) || (char_i == MINUS);
    is_neg_o   = (char_i == MINUS);
    is_lf_o    = (char_i == LF);
    is_cr_o    = (char_i == CR);
    digit_o    = offset[3:0];
  end

endmodule

// File: rtl/calibration_list_loader.sv
// Parses an ASCII stream of signed decimal lines and writes each value into the
// calibration list. Define CAL_LOADER_SUM_EN to add the running-sum output sum_out.
module calibration_list_loader
  import cal_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_last,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]        list_length,
  output logic                         busy,
  output logic                         done,
`ifdef CAL_LOADER_SUM_EN
  output logic signed [DATA_WIDTH-1:0] sum_out,
`endif
  output logic                         error
);

  localparam int unsigned AccW = DATA_WIDTH + 4;
  localparam logic [AccW-1:0] MagMax = AccW'(1) << (DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ListMax = '1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    neg_q, neg_d;
  logic                    sign_seen_q, sign_seen_d;
  logic                    digit_seen_q, digit_seen_d;
  logic                    last_q, last_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
`ifdef CAL_LOADER_SUM_EN
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
`endif

  logic                    cls_is_digit, cls_is_sign, cls_is_neg, cls_is_lf, cls_is_cr;
  logic [3:0]              cls_digit;
  logic [AccW-1:0]         acc_ext;
  logic [DATA_WIDTH-1:0]   value;
  logic                    bad, commit;

  ascii_char_classify u_classify (
    .char_i     (byte_data),
    .is_digit_o (cls_is_digit),
    .is_sign_o  (cls_is_sign),
    .is_neg_o   (cls_is_neg),
    .is_lf_o    (cls_is_lf),
    .is_cr_o    (cls_is_cr),
    .digit_o    (cls_digit)
  );

  // Next-state, line parsing and list write strobe.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    sign_seen_d  = sign_seen_q;
    digit_seen_d = digit_seen_q;
    last_d       = last_q;
    error_d      = error_q;
    len_d        = len_q;
`ifdef CAL_LOADER_SUM_EN
    sum_d        = sum_q;
`endif
    byte_ready   = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    bad          = 1'b0;
    commit       = 1'b0;
    // Wide accumulate so the overflow check sees the true magnitude.
    acc_ext      = AccW'(acc_q) * AccW'(10) + AccW'(cls_digit);
    value        = neg_q ? -acc_q : acc_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LINE;
          len_d        = '0;
          error_d      = 1'b0;
          acc_d        = '0;
          neg_d        = 1'b0;
          sign_seen_d  = 1'b0;
          digit_seen_d = 1'b0;
          last_d       = 1'b0;
`ifdef CAL_LOADER_SUM_EN
          sum_d        = '0;
`endif
        end
      end
      LINE: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (cls_is_digit) begin
            // -2**(W-1) is representable, +2**(W-1) is not.
            if ((acc_ext > MagMax) || ((acc_ext == MagMax) && !neg_q)) begin
              bad = 1'b1;
            end else begin
              acc_d        = acc_ext[DATA_WIDTH-1:0];
              digit_seen_d = 1'b1;
            end
          end else if (cls_is_sign) begin
            if (sign_seen_q || digit_seen_q) begin
              bad = 1'b1;
            end else begin
              sign_seen_d = 1'b1;
              neg_d       = cls_is_neg;
            end
          end else if (cls_is_lf) begin
            if (digit_seen_q) begin
              commit = 1'b1;
            end else begin
              acc_d        = '0;
              neg_d        = 1'b0;
              sign_seen_d  = 1'b0;
              digit_seen_d = 1'b0;
            end
          end else if (!cls_is_cr) begin
            bad = 1'b1;
          end

          if (bad) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (commit) begin
            state_d = WRITE;
            last_d  = byte_last;
          end else if (byte_last) begin
            // Final byte with an unterminated number still gets committed.
            if (digit_seen_d) begin
              state_d = WRITE;
              last_d  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      WRITE: begin
        if (len_q == ListMax) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wr_en   = 1'b1;
          wr_addr = len_q;
          wr_data = value;
          len_d   = len_q + 1'b1;
`ifdef CAL_LOADER_SUM_EN
          sum_d   = sum_q + value;
`endif
          state_d = last_q ? DONE : LINE;
        end
        acc_d        = '0;
        neg_d        = 1'b0;
        sign_seen_d  = 1'b0;
        digit_seen_d = 1'b0;
        last_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      sign_seen_q  <= 1'b0;
      digit_seen_q <= 1'b0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      len_q        <= '0;
`ifdef CAL_LOADER_SUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      sign_seen_q  <= sign_seen_d;
      digit_seen_q <= digit_seen_d;
      last_q       <= last_d;
      error_q      <= error_d;
      len_q        <= len_d;
`ifdef CAL_LOADER_SUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign busy        = (state_q == LINE) || (state_q == WRITE);
  assign done        = (state_q == DONE);
  assign error       = error_q;
  assign list_length = len_q;
`ifdef CAL_LOADER_SUM_EN
  assign sum_out     = sum_q;
`endif

endmodule

// File: tb/tb_calibration_list_loader.sv
// Directed bench for calibration_list_loader with hand-computed expectations.
module tb_calibration_list_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, byte_valid, byte_ready, byte_last;
  logic [7:0]  byte_data;
  logic        wr_en, busy, done, error;
  logic [9:0]  wr_addr, list_length;
  logic [19:0] wr_data;
`ifdef CAL_LOADER_SUM_EN
  logic [19:0] sum_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [9:0]  wa[$];
  logic [19:0] wd[$];
  logic [19:0] exp_q[$];

  calibration_list_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .list_length (list_length),
    .busy        (busy),
    .done        (done),
`ifdef CAL_LOADER_SUM_EN
    .sum_out     (sum_out),
`endif
    .error       (error)
  );

  always #5 CLK = ~CLK;

  // Record every list write away from the rising edge.
  always @(negedge CLK) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    wa.delete();
    wd.delete();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int stall);
    int n = 0;
    repeat (stall) begin
      @(posedge CLK); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    while (!byte_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!byte_ready) begin
      check_eq("handshake_timeout", 32'(byte_ready), 32'd1);
    end else begin
      @(posedge CLK); #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_final, input int stall_max);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_final && (i == s.len() - 1),
                (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_count"}, 32'(wd.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), (i < wa.size()) ? 32'(wa[i]) : 32'hxxxx_xxxx,
               32'(i));
      check_eq($sformatf("%s_data%0d", tag, i), (i < wd.size()) ? 32'(wd[i]) : 32'hxxxx_xxxx,
               32'(exp_q[i]));
    end
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_len", 32'(list_length), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Basic four-line stream, with write latency checked on the first line.
    do_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    send_byte("+", 1'b0, 0);
    send_byte("1", 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    check_eq("t1_lat_wr_en", 32'(wr_en), 32'd1);
    check_eq("t1_lat_data", 32'(wr_data), 32'h1);
    check_eq("t1_ready_in_write", 32'(byte_ready), 32'd0);
    send_str("-2\n+3\n+1\n", 1'b1, 0);
    wait_done("t1_done");
    exp_q = '{20'h00001, 20'hFFFFE, 20'h00003, 20'h00001};
    check_writes("t1");
    check_eq("t1_len", 32'(list_length), 32'd4);
    check_eq("t1_error", 32'(error), 32'd0);
`ifdef CAL_LOADER_SUM_EN
    check_eq("t1_sum", 32'(sum_out), 32'd3);
`endif

    // No trailing LF: byte_last on the final digit commits it.
    do_start();
    check_eq("t2_done_cleared", 32'(done), 32'd0);
    send_str("-1\n-2\n-3", 1'b1, 0);
    wait_done("t2_done");
    exp_q = '{20'hFFFFF, 20'hFFFFE, 20'hFFFFD};
    check_writes("t2");
    check_eq("t2_len", 32'(list_length), 32'd3);

    // Blank and CR-only lines are skipped.
    do_start();
    send_str("+7\n\n", 1'b0, 0);
    send_byte(8'h0D, 1'b0, 0);
    send_str("\n+5\n", 1'b1, 0);
    wait_done("t3_done");
    exp_q = '{20'h00007, 20'h00005};
    check_writes("t3");
    check_eq("t3_len", 32'(list_length), 32'd2);
    check_eq("t3_error", 32'(error), 32'd0);

    // Bad character stops the load at once.
    do_start();
    send_str("+12x", 1'b0, 0);
    check_eq("t4_error", 32'(error), 32'd1);
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_writes", 32'(wd.size()), 32'd0);
    check_eq("t4_len", 32'(list_length), 32'd0);

    // Most-negative value accepted, its positive twin rejected; random stalls.
    do_start();
    send_str("-524288\n", 1'b1, 3);
    wait_done("t5_done");
    exp_q = '{20'h80000};
    check_writes("t5");
    check_eq("t5_error", 32'(error), 32'd0);
    do_start();
    check_eq("t5_error_cleared", 32'(error), 32'd0);
    send_str("+524288", 1'b0, 3);
    check_eq("t6_error", 32'(error), 32'd1);
    check_eq("t6_done", 32'(done), 32'd1);
    check_eq("t6_len", 32'(list_length), 32'd0);
    check_eq("t6_writes", 32'(wd.size()), 32'd0);
    check_eq("t6_no_write_now", 32'(wr_en), 32'd0);

    // Asynchronous reset mid-load, then restart; start while busy is ignored.
    do_start();
    send_str("+8\n+3", 1'b0, 0);
    check_eq("t7_len_pre", 32'(list_length), 32'd1);
    RST = 1'b0;
    #2;
    check_eq("t7_rst_len", 32'(list_length), 32'd0);
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_ready", 32'(byte_ready), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    do_start();
    send_str("+4\n", 1'b0, 0);
    @(posedge CLK); #1;
    check_eq("t7_len_mid", 32'(list_length), 32'd1);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check_eq("t7_busy_after_start", 32'(busy), 32'd1);
    check_eq("t7_len_after_start", 32'(list_length), 32'd1);
    send_byte(8'h0A, 1'b1, 0);
    wait_done("t7_done");
    exp_q = '{20'h00004};
    check_writes("t7");
    check_eq("t7_len", 32'(list_length), 32'd1);
    check_eq("t7_error", 32'(error), 32'd0);

    // Fill the list to capacity; the next commit is refused with an error.
    do_start();
    for (int i = 0; i < 1023; i++) begin
      send_str("+1\n", 1'b0, 0);
    end
    @(posedge CLK); #1;
    check_eq("t8_len_full", 32'(list_length), 32'd1023);
    check_eq("t8_error_pre", 32'(error), 32'd0);
    send_str("+2\n", 1'b1, 0);
    wait_done("t8_done");
    check_eq("t8_error", 32'(error), 32'd1);
    check_eq("t8_len", 32'(list_length), 32'd1023);
    check_eq("t8_writes", 32'(wd.size()), 32'd1023);
    check_eq("t8_last_addr", (wa.size() == 1023) ? 32'(wa[1022]) : 32'hxxxx_xxxx, 32'd1022);
`ifdef CAL_LOADER_SUM_EN
    check_eq("t8_sum", 32'(sum_out), 32'd1023);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calibration_list_loader.md
Name: calibration_list_loader

Overview:
- Upstream feeder of the frequency calibrator. Consumes the puzzle input as an ASCII byte stream (lines such as "+1\n-2\n") and parses each line into a signed DATA_WIDTH value.
- Writes each value into the calibration list memory and publishes list_length for the calibrator.
- Replaces the bench-side file scan, so the calibration path can be fed from a byte source such as a UART or ROM.

Parameters:
- DATA_WIDTH, 20, width of each signed calibration value.
- ADDR_WIDTH, 10, list address width; capacity is 2**ADDR_WIDTH-1 entries.

Ports:
- CLK  in  1  clock; all flops update on the rising edge.
- RST  in  1  reset, asynchronous assert, active-low (0 = reset).
- start  in  1  one-cycle pulse; clears the list and begins a load.
- byte_valid  in  1  upstream byte available.
- byte_ready  out  1  loader accepts the byte this cycle.
- byte_data  in  8  ASCII byte.
- byte_last  in  1  qualifies the final byte of the stream.
- wr_en  out  1  list write strobe.
- wr_addr  out  ADDR_WIDTH  list write index.
- wr_data  out  DATA_WIDTH  signed value written.
- list_length  out  ADDR_WIDTH  number of committed entries.
- busy  out  1  load in progress.
- done  out  1  sticky; load finished.
- error  out  1  sticky; bad character, magnitude overflow or list full.

Behaviour:
- Reset values: byte_ready, wr_en, busy, done, error = 0; wr_addr, wr_data, list_length = 0; state = IDLE; accumulator, sign and digit-seen flag cleared.
- Handshake: a byte transfers when byte_valid && byte_ready. byte_ready=1 only in LINE state; upstream must hold the byte until it is accepted.
- IDLE: start -> clear list_length, done, error; busy=1; go to LINE. start is ignored in every other state.
- LINE, one byte per cycle:
  - '+' or '-' as the first char of a line sets the sign.
  - '0'-'9': acc <= acc*10 + digit; mark digit seen. The computation is done in DATA_WIDTH+4 bits.
  - If magnitude exceeds 2**(DATA_WIDTH-1)-1 (a magnitude of 2**(DATA_WIDTH-1) is accepted only with a '-' sign), set error and go to DONE.
  - '\r' is ignored.
  - '\n' with a digit seen goes to WRITE. '\n' with no digit seen is a blank line: ignored, line state cleared.
  - Any other byte, or a second sign, or a sign after a digit: error, go to DONE.
- byte_last on an accepted byte: after processing that byte, commit any pending digits through WRITE, then go to DONE. If nothing is pending, go straight to DONE.
- WRITE, exactly one cycle:
  - wr_en=1; wr_addr=list_length; wr_data = sign ? -acc : acc.
  - list_length increments on the next edge; line state is cleared; byte_ready=0 during this cycle.
  - Return to LINE, or DONE if byte_last was pending.
  - Latency: wr_en is asserted the cycle after the '\n' handshake.
- List full: if a commit arrives while list_length == 2**ADDR_WIDTH-1, suppress wr_en, set error, go to DONE. No wrap-around.
- DONE: busy=0, done=1. Hold until the next start, which goes straight to LINE. done and error clear on that start.
- An asynchronous reset mid-load aborts immediately to the reset values. Partial list contents are undefined.

Optional Feature:
- Macro CAL_LOADER_SUM_EN.
- Defined: adds output sum_out (signed DATA_WIDTH), the running sum of all committed values. It is cleared on start and updated on the same edge as list_length, with wrapping two's-complement addition. This allows a part-1 cross-check without running the calibrator.
- Undefined: the port and its adder are absent; all other behaviour is unchanged.

Decomposition:
- Package cal_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - ASCII constants (PLUS, MINUS, LF, CR, DIGIT_0);
  - the state enum {IDLE, LINE, WRITE, DONE}.
- Sub-module ascii_char_classify: byte in -> {is_digit, is_sign, is_neg, is_lf, is_cr, digit[3:0]}. Single instance.

Test Plan:
- Stream "+1\n-2\n+3\n+1\n": writes 1, -2, 3, 1 at addresses 0-3; list_length=4; done=1; error=0; sum_out=3 when enabled.
- "-1\n-2\n-3" with byte_last on '3', no trailing LF: three writes, last value -3; list_length=3.
- "+7\n\n\r\n+5\n": blank and CR lines skipped; list_length=2; values 7, 5.
- "+12x\n": error=1 and done=1 when 'x' is accepted; no write occurs; list_length=0.
- "-524288\n" accepted (wr_data=0x80000); "+524288\n" -> error. Stalling byte_valid low for random cycles does not change the results.
- Assert RST=0 mid-stream, then restart with "+4\n": list_length=1, value 4; start pulses while busy are ignored.
